mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand width. Only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only while idle.
REQ-005 SHALL have port op, input, 1 bit: operation select; 0 = MULT, 1 = DIV.
REQ-006 SHALL have port a, input, 32 bits: signed rs operand (multiplicand / dividend).
REQ-007 SHALL have port b, input, 32 bits: signed rt operand (multiplier / divisor).
REQ-008 SHALL have port hi, output, 32 bits: HI register; feeds the write-back select mux.
REQ-009 SHALL have port lo, output, 32 bits: LO register; feeds the write-back select mux.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse signalling that hi/lo are final.
REQ-012 SHALL have port div_zero, output, 1 bit: the last DIV had b == 0; held until the next accepted start.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC, FINISH.
- IDLE -> CALC on start = 1.
- CALC -> FINISH after 32 iterations.
- FINISH -> IDLE unconditionally.
REQ-014 SHALL latch a, b and op at the accepting edge E0, clear the iteration counter and clear div_zero.
REQ-015 SHALL perform one iteration per cycle at edges E1..E32, using a 6-bit counter, and write hi/lo at edge E33, with done = 1 for exactly the cycle that follows E33.
REQ-016 SHALL, for MULT, produce {hi,lo} = the full signed 64-bit product using radix-2 Booth iteration.
REQ-017 SHALL, for DIV, produce lo = signed quotient truncated toward zero and hi = remainder carrying the dividend's sign; magnitudes use restoring division, with a sign fix applied at FINISH.
REQ-018 SHALL, for DIV with b = 0, set div_zero = 1 at E0, skip CALC, go directly to FINISH, leave hi/lo unchanged, and pulse done after E1.
REQ-019 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo = 0x80000000 and hi = 0, with no flag raised.
REQ-020 SHALL ignore start while busy = 1; latched operands and progress are unaffected.
REQ-021 SHALL hold hi/lo stable at all times except the FINISH write; done SHALL be 0 except in the post-FINISH cycle.
REQ-022 SHALL accept a start asserted in the same cycle that done is high (state is IDLE then), giving back-to-back operations.

Reset
REQ-023 SHALL, while reset_n = 0 at a rising edge, force state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0 and counter = 0.
REQ-024 SHALL, on reset mid-operation, abort the operation with no hi/lo write; the first start after reset release SHALL behave normally.

Configuration
REQ-025 SHALL compile the divider datapath only when the macro MULT_DIV_DIVIDE_EN is defined.
REQ-026 SHALL, with MULT_DIV_DIVIDE_EN defined, implement REQ-017 to REQ-019 as specified.
REQ-027 SHALL, without MULT_DIV_DIVIDE_EN, treat start with op = 1 as a no-op: IDLE -> FINISH, done pulse after E1, hi/lo unchanged, div_zero stays 0. The div_zero port remains present, tied to 0.

Structure
REQ-028 SHALL place the state enum, the OP_MULT/OP_DIV constants and ITER_CNT = 32 in shared package mult_div_pkg.
REQ-029 SHALL use one combinational sub-module, div_step (a single restoring subtract/shift step), instantiated only under MULT_DIV_DIVIDE_EN; the Booth step stays inline.

Verification
REQ-030 SHALL cover: MULT a = 7, b = -3 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; done 34 cycles after the start edge; busy high for 33 cycles.
REQ-031 SHALL cover: MULT 0x7FFFFFFF x 0x7FFFFFFF -> hi = 0x3FFFFFFF, lo = 0x00000001; then back-to-back MULT 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0.
REQ-032 SHALL cover: DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 7 / -2 -> lo = 0xFFFFFFFD, hi = 1.
REQ-033 SHALL cover: DIV 5 / 0 with hi/lo preloaded to 1 and 2 -> div_zero = 1, done 2 cycles after start, hi/lo still 1 and 2; next start clears div_zero.
REQ-034 SHALL cover: DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0; a start pulse at iteration 5 is ignored and the result is unchanged.
REQ-035 SHALL cover: reset_n low at iteration 10 of a MULT -> all outputs 0 next cycle, no done pulse; a subsequent MULT 3 x 4 -> lo = 12.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The MULT_DIV_DIVIDE_EN macro selects the divider datapath in mult_div.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int         ITER_CNT = 32;
  localparam logic [5:0] CNT_LAST = 6'(ITER_CNT - 1);

  // Two's-complement negate when sel is set; used for magnitudes and sign fix-up.
  function automatic logic [31:0] neg_if(input logic sel, input logic [31:0] v);
    return sel ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
// Purely combinational; only built when MULT_DIV_DIVIDE_EN is defined.
`ifdef MULT_DIV_DIVIDE_EN
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvsr,
  output logic [31:0] rem_nxt,
  output logic [31:0] quo_nxt
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // rem < dvsr <= 2^31 always, so shifted < 2^32 and diff[32] is a clean borrow.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end else begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end
  end

endmodule
`endif

// File: rtl/mult_div.sv
// Iterative signed 32x32 Booth multiplier / restoring divider into HI/LO; 34 cycles per op, 2 for div-by-zero.
// No backpressure: start is taken only while idle and ignored while busy. Divider built with MULT_DIV_DIVIDE_EN.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [32:0] acc;
  logic [31:0] qreg;
  logic        q_1;
  logic [32:0] mreg;
  logic        op_r;
  logic [32:0] booth_sum;

`ifdef MULT_DIV_DIVIDE_EN
  logic        dz_r;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  div_step u_div_step (
    .rem     (acc[31:0]),
    .quo     (qreg),
    .dvsr    (mreg[31:0]),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign div_zero = dz_r;
`else
  assign div_zero = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_DIV) begin
`ifdef MULT_DIV_DIVIDE_EN
            state_nxt = (b == '0) ? FINISH : CALC;
`else
            state_nxt = FINISH;
`endif
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC:    if (cnt == CNT_LAST) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Radix-2 Booth: acc is one bit wider than the operand so -2^31 as multiplicand cannot overflow.
  always_comb begin
    booth_sum = acc;
    case ({qreg[0], q_1})
      2'b01:   booth_sum = acc + mreg;
      2'b10:   booth_sum = acc - mreg;
      default: booth_sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      acc   <= '0;
      qreg  <= '0;
      q_1   <= 1'b0;
      mreg  <= '0;
      op_r  <= OP_MULT;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      dz_r  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            cnt  <= '0;
            acc  <= '0;
            q_1  <= 1'b0;
            qreg <= b;
            mreg <= {a[31], a};
`ifdef MULT_DIV_DIVIDE_EN
            dz_r <= 1'b0;
            if (op == OP_DIV) begin
              qreg  <= neg_if(a[31], a);
              mreg  <= {1'b0, neg_if(b[31], b)};
              neg_q <= a[31] ^ b[31];
              neg_r <= a[31];
              dz_r  <= (b == '0);
            end
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (op_r == OP_MULT) begin
            {acc, qreg, q_1} <= {booth_sum[32], booth_sum, qreg};
          end
`ifdef MULT_DIV_DIVIDE_EN
          else begin
            acc  <= {1'b0, rem_nxt};
            qreg <= quo_nxt;
          end
`endif
        end
        FINISH: begin
          done <= 1'b1;
          if (op_r == OP_MULT) begin
            hi <= acc[31:0];
            lo <= qreg;
          end
`ifdef MULT_DIV_DIVIDE_EN
          else if (!dz_r) begin
            lo <= neg_if(neg_q, qreg);
            hi <= neg_if(neg_r, acc[31:0]);
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed-vector bench for mult_div; expectations adapt to whether MULT_DIV_DIVIDE_EN is defined.
module tb_mult_div;

`ifdef MULT_DIV_DIVIDE_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_div #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    logic        keep;
  } vec_t;

  vec_t tv[9];

  int          lat;
  int          bcnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dz;
  logic        done_at_start;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge. Latency k counts falling edges after the accepting edge.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int glitch_k);
    done_at_start = done;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k; r_hi = hi; r_lo = lo; r_dz = div_zero;
        break;
      end
      if (k == 1) begin start = 1'b0; op = 1'b0; a = '0; b = '0; end
      if (glitch_k > 0 && k == glitch_k) begin
        start = 1'b1; op = ~o; a = 32'h0000_1234; b = 32'h0000_5678;
      end
      if (glitch_k > 0 && k == glitch_k + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    tv[0] = '{"mul_7_m3",   1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b0};
    tv[1] = '{"mul_max",    1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 34, 1'b0};
    tv[2] = '{"mul_min",    1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34, 1'b0};
    tv[3] = '{"div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_ON ? 34 : 2, !DIV_ON};
    tv[4] = '{"div_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, DIV_ON ? 34 : 2, !DIV_ON};
    tv[5] = '{"mul_0_5",    1'b0, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000, 1'b0, 34, 1'b0};
    tv[6] = '{"div_100_7",  1'b1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, DIV_ON ? 34 : 2, !DIV_ON};
    tv[7] = '{"mul_m1_m1",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34, 1'b0};
    tv[8] = '{"div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, DIV_ON ? 34 : 2, !DIV_ON};

    reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table runs back-to-back: each start is raised in the cycle done is high.
    exp_hi = '0; exp_lo = '0;
    for (int i = 0; i < 9; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, 0);
      if (!tv[i].keep) begin
        exp_hi = tv[i].hi;
        exp_lo = tv[i].lo;
      end
      chk({tv[i].name, "_hi"}, r_hi, exp_hi);
      chk({tv[i].name, "_lo"}, r_lo, exp_lo);
      chk({tv[i].name, "_dz"}, r_dz, tv[i].dz);
      chk({tv[i].name, "_lat"}, lat, tv[i].lat);
      chk({tv[i].name, "_busy"}, bcnt, tv[i].lat - 1);
      if (i > 0) chk({tv[i].name, "_b2b"}, done_at_start, 1);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Divide by zero with HI/LO preloaded to 1/2 via 6 * 0x2AAAAAAB = 0x1_0000_0002.
    do_op(1'b0, 32'd6, 32'h2AAA_AAAB, 0);
    chk("preload_hi", r_hi, 32'd1);
    chk("preload_lo", r_lo, 32'd2);
    @(negedge clk);
    do_op(1'b1, 32'd5, 32'd0, 0);
    chk("dz_flag", r_dz, DIV_ON);
    chk("dz_lat", lat, 2);
    chk("dz_busy", bcnt, 1);
    chk("dz_hi", r_hi, 32'd1);
    chk("dz_lo", r_lo, 32'd2);
    @(negedge clk);
    chk("dz_held", div_zero, DIV_ON);
    chk("dz_done_low", done, 0);
    do_op(1'b0, 32'd3, 32'd4, 0);
    chk("dz_cleared", r_dz, 0);
    chk("after_dz_lo", r_lo, 32'd12);

    // Start pulse at iteration 5 must not disturb the running operation.
    @(negedge clk);
    do_op(DIV_ON, DIV_ON ? 32'h8000_0000 : 32'd7, DIV_ON ? 32'hFFFF_FFFF : 32'hFFFF_FFFD, 5);
    chk("glitch_lat", lat, 34);
    chk("glitch_hi", r_hi, DIV_ON ? 32'h0000_0000 : 32'hFFFF_FFFF);
    chk("glitch_lo", r_lo, DIV_ON ? 32'h8000_0000 : 32'hFFFF_FFEB);
    @(negedge clk);
    chk("glitch_idle_busy", busy, 0);
    chk("glitch_hold_lo", lo, DIV_ON ? 32'h8000_0000 : 32'hFFFF_FFEB);

    // Reset at iteration 10 of a multiply aborts it with all outputs cleared.
    op = 1'b0; a = 32'h0001_2345; b = 32'h0000_0100; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dz", div_zero, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    do_op(1'b0, 32'd3, 32'd4, 0);
    chk("post_rst_lo", r_lo, 32'd12);
    chk("post_rst_hi", r_hi, 32'd0);
    chk("post_rst_lat", lat, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
